// File: rtl/pipelined_adder_pkg.sv
// Shared adder opcodes and default geometry, also used by the ALU.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 16;

    function automatic int num_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cla_n_bit.sv
// N-bit carry-lookahead slice using a parallel-prefix (Kogge-Stone) carry tree.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline owns flow control.
module cla_n_bit #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N-1:0] grp_g;
    logic [N-1:0] grp_p;
    logic [N:0]   carry;

    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        grp_g = gen;
        grp_p = prop;
        // Descending index keeps reads at i-d on the previous prefix level.
        for (int d = 1; d < N; d = d * 2) begin
            for (int i = N - 1; i >= d; i--) begin
                grp_g[i] = grp_g[i] | (grp_p[i] & grp_g[i-d]);
                grp_p[i] = grp_p[i] & grp_p[i-d];
            end
        end
        carry[0] = c_in;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = grp_g[i] | (grp_p[i] & c_in);
        end
        sum   = prop ^ carry[N-1:0];
        c_out = carry[N];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub, one CHUNK-bit CLA slice per stage, flags for the ALU.
// Latency: STAGES = WIDTH/CHUNK cycles from acceptance to out_valid when not stalled.
// Backpressure: global stall; in_ready = ~out_valid | out_ready, all stages hold together.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = num_stages(WIDTH, CHUNK);
    localparam int MSB    = WIDTH - 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
        $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    // Operands travel whole; each stage consumes its own slice and fills its sum slice.
    typedef struct packed {
        logic             vld;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } stage_t;

    stage_t           stage_in [STAGES];
    stage_t           stage_d  [STAGES];
    stage_t           stage_q  [STAGES];
    logic [CHUNK-1:0] slice_sum  [STAGES];
    logic             slice_cout [STAGES];
    logic             advance;
    logic             zero_d;
    logic             zero_q;
    logic             overflow_d;
    logic             overflow_q;

    assign advance  = ~stage_q[STAGES-1].vld | out_ready;
    assign in_ready = advance;

    always_comb begin
        stage_in[0].vld   = in_valid;
        stage_in[0].carry = (op == OP_SUB) ? 1'b1 : c_in;
        stage_in[0].a     = a;
        stage_in[0].b     = (op == OP_SUB) ? ~b : b;
        stage_in[0].sum   = '0;
        for (int k = 1; k < STAGES; k++) begin
            stage_in[k] = stage_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        cla_n_bit #(.N(CHUNK)) u_cla (
            .a     (stage_in[k].a[k*CHUNK +: CHUNK]),
            .b     (stage_in[k].b[k*CHUNK +: CHUNK]),
            .c_in  (stage_in[k].carry),
            .sum   (slice_sum[k]),
            .c_out (slice_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k]                         = stage_in[k];
            stage_d[k].carry                   = slice_cout[k];
            stage_d[k].sum[k*CHUNK +: CHUNK]   = slice_sum[k];
        end
        // Flags are resolved alongside the last slice so outputs come straight from flops.
        zero_d     = (stage_d[STAGES-1].sum == '0);
        overflow_d = (stage_in[STAGES-1].a[MSB] == stage_in[STAGES-1].b[MSB]) &
                     (stage_d[STAGES-1].sum[MSB] != stage_in[STAGES-1].a[MSB]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
            zero_q     <= zero_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = stage_q[STAGES-1].vld;
    assign sum       = stage_q[STAGES-1].sum;
    assign c_out     = stage_q[STAGES-1].carry;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: three geometries (32/16, 64/16, 8/8) share one stimulus stream.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    typedef struct {
        logic [63:0] sum;
        logic        co;
        logic        ov;
        logic        z;
        int          cyc;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] a_s = '0;
    logic [63:0] b_s = '0;
    logic        c_in_s = 1'b0;
    logic        op_s = OP_ADD;
    logic        rand_done = 1'b0;
    logic        rdy_w [3];
    int          pending [3];
    int          cyc = 0;
    int          stall_cnt = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (!out_ready) stall_cnt++;
    end

    function automatic int cfg_w(input int i);
        return (i == 0) ? 32 : (i == 1) ? 64 : 8;
    endfunction

    function automatic int cfg_c(input int i);
        return (i == 0) ? 16 : (i == 1) ? 16 : 8;
    endfunction

    function automatic void chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference: unsigned and signed arithmetic on wide integers, truncated to w bits.
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic cin, input logic opv);
        exp_t               e;
        logic [66:0]        modv, ua, ub, full;
        logic signed [66:0] sa, sb, sr, lim;
        modv = 67'd1 << w;
        ua   = {3'b000, av} & (modv - 67'd1);
        ub   = {3'b000, bv} & (modv - 67'd1);
        sa   = $signed(ua);
        sb   = $signed(ub);
        if (ua >= (modv >> 1)) sa = sa - $signed(modv);
        if (ub >= (modv >> 1)) sb = sb - $signed(modv);
        lim  = $signed(modv >> 1);
        if (opv == OP_ADD) begin
            full = ua + ub + {66'd0, cin};
            e.co = (full >= modv);
            sr   = sa + sb + $signed({66'd0, cin});
        end else begin
            full = ua - ub;
            e.co = (ua >= ub);
            sr   = sa - sb;
        end
        e.sum    = 64'(full & (modv - 67'd1));
        e.ov     = (sr >= lim) || (sr < -lim);
        e.z      = (e.sum == 64'd0);
        e.cyc    = 0;
        e.stalls = 0;
        return e;
    endfunction

    for (genvar G = 0; G < 3; G++) begin : g_dut
        localparam int W = cfg_w(G);
        localparam int C = cfg_c(G);
        localparam int S = W / C;

        logic         in_ready, out_valid, c_out, overflow, zero;
        logic [W-1:0] sum;
        exp_t         exp_q [$];
        logic         held = 1'b0;
        logic [95:0]  held_v = '0;

        pipelined_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a_s[W-1:0]),
            .b         (b_s[W-1:0]),
            .c_in      (c_in_s),
            .op        (op_s),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .c_out     (c_out),
            .overflow  (overflow),
            .zero      (zero)
        );

        assign rdy_w[G] = in_ready;

        always @(negedge clk) begin : push
            exp_t e;
            if (rst) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                e        = model(W, a_s, b_s, c_in_s, op_s);
                e.cyc    = cyc;
                e.stalls = stall_cnt;
                exp_q.push_back(e);
            end
            pending[G] = exp_q.size();
        end

        always @(negedge clk) begin : monitor
            exp_t e;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held)
                    chk($sformatf("w%0d_stall_hold", W),
                        96'({out_valid, 64'(sum), c_out, overflow, zero}), held_v);
                held = out_valid && !out_ready;
                if (held) begin
                    held_v = 96'({out_valid, 64'(sum), c_out, overflow, zero});
                    chk($sformatf("w%0d_stall_in_ready", W), 96'(in_ready), 96'd0);
                end
                if (out_valid && out_ready) begin
                    chk($sformatf("w%0d_result_expected", W), 96'(exp_q.size() != 0), 96'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("w%0d_result", W),
                            96'({64'(sum), c_out, overflow, zero}), 96'({e.sum, e.co, e.ov, e.z}));
                        if (e.stalls == stall_cnt)
                            chk($sformatf("w%0d_latency", W), 96'(cyc - e.cyc), 96'(S));
                    end
                end
            end
            pending[G] = exp_q.size();
        end

        always @(posedge rst) begin
            #1;
            chk($sformatf("w%0d_reset_outputs", W),
                96'({out_valid, 64'(sum), c_out, overflow, zero}), 96'd0);
        end

        always @(negedge rst) begin
            #1;
            chk($sformatf("w%0d_release_ready", W), 96'({in_ready, out_valid}), 96'b10);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds operands until the 32-bit instance accepts; other instances record their own accepts.
    task automatic send(input logic [63:0] av, input logic [63:0] bv, input logic cin, input logic opv);
        int n;
        in_valid = 1'b1;
        a_s      = av;
        b_s      = bv;
        c_in_s   = cin;
        op_s     = opv;
        n        = 0;
        @(negedge clk);
        while (!rdy_w[0] && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("send_accepted", 96'(rdy_w[0]), 96'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Per-byte corner bias so every width sees 0, all-ones and sign-boundary operands.
    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 4))
                0:       v[i*8 +: 8] = 8'h00;
                1:       v[i*8 +: 8] = 8'hFF;
                2:       v[i*8 +: 8] = 8'h7F;
                3:       v[i*8 +: 8] = 8'h80;
                default: v[i*8 +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        send(64'h0000_FFFF, 64'd1, 1'b0, OP_ADD);
        send(64'd5, 64'd5, 1'b0, OP_SUB);
        send(64'd3, 64'd5, 1'b0, OP_SUB);
        send(64'h7FFF_FFFF, 64'd1, 1'b0, OP_ADD);
        send(64'hFFFF_FFFF, 64'd1, 1'b0, OP_ADD);
        send(64'h1234_5678, 64'h0FED_CBA9, 1'b1, OP_ADD);
        idle(6);

        fork
            for (int i = 1; i <= 4; i++) send(64'(i), 64'(i), 1'b0, OP_ADD);
            begin
                idle(2);
                out_ready = 1'b0;
                idle(3);
                out_ready = 1'b1;
            end
        join
        idle(8);

        send(64'd10, 64'd20, 1'b0, OP_ADD);
        send(64'd30, 64'd40, 1'b1, OP_ADD);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(8);
        send(64'd100, 64'd23, 1'b1, OP_ADD);
        idle(6);

        fork
            begin
                for (int i = 0; i < 1200; i++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                    send(rnd64(), rnd64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    idle(1);
                    out_ready = ($urandom_range(0, 4) != 0);
                end
            end
        join
        out_ready = 1'b1;
        idle(20);

        for (int i = 0; i < 3; i++) chk($sformatf("drain_%0d", i), 96'(pending[i]), 96'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
